narrowing_sign_reducer: RTL and testbench

//  Streaming inverse of the 5->8 bit sign extender: narrows signed IN_W-bit values to signed OUT_W-bit immediates.

---
 rtl/narrowing_sign_reducer.sv | 82 ++++++++
 tb/tb_narrowing_sign_reducer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/narrowing_sign_reducer.sv
// narrowing_sign_reducer: narrows signed IN_W words to signed OUT_W immediates, flags words
// that do not fit (optionally saturating them) behind one registered valid/ready output stage.
module narrowing_sign_reducer #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 5,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             sat_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_ovf,
   input  logic             clear_ovf,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] ovf_count
);

   // head = the dropped bits plus the new sign bit; a word fits when all of them agree
   localparam int HEAD_W = IN_W - OUT_W + 1;

   localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [HEAD_W-1:0] head;
   logic              fits;
   logic [OUT_W-1:0]  narrowed;
   logic              accept;
   logic              ovf_event;

   assign head      = in_data[IN_W-1:OUT_W-1];
   assign fits      = (head == '0) || (head == '1);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign ovf_event = accept && !fits;

   always_comb begin
      narrowed = in_data[OUT_W-1:0];
      if (!fits && sat_en) begin
         narrowed = in_data[IN_W-1] ? SAT_MIN : SAT_MAX;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= narrowed;
         out_ovf   <= !fits;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // an overflow accepted in the clear cycle is counted as the first event after the clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ovf_sticky <= 1'b0;
         ovf_count  <= '0;
      end else if (ovf_event) begin
         ovf_sticky <= 1'b1;
         if (clear_ovf) begin
            ovf_count <= CNT_ONE;
         end else if (ovf_count != CNT_MAX) begin
            ovf_count <= ovf_count + CNT_ONE;
         end
      end else if (clear_ovf) begin
         ovf_sticky <= 1'b0;
         ovf_count  <= '0;
      end
   end

endmodule

// File: tb/tb_narrowing_sign_reducer.sv
// Self-checking bench for narrowing_sign_reducer: directed scenarios plus a randomized stream
// checked against a transaction-level model of the 8->5 narrowing rules.
module tb_narrowing_sign_reducer;

   logic       clock;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       sat_en;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] out_data;
   logic       out_ovf;
   logic       clear_ovf;
   logic       ovf_sticky;
   logic [7:0] ovf_count;

   int checks   = 0;
   int failures = 0;

   // model of the pending output word and of the overflow monitor
   logic       m_valid;
   logic [4:0] m_data;
   logic       m_ovf;
   logic       m_sticky;
   int         m_cnt;

   narrowing_sign_reducer #(.IN_W(8), .OUT_W(5), .CNT_W(8)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .sat_en(sat_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
      .clear_ovf(clear_ovf), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // value-level narrowing rule: fits iff -16 <= v <= 15
   function automatic void ref_narrow(input logic [7:0] d, input logic sat,
                                      output logic [4:0] o, output logic ovf);
      int v;
      int w;
      v = int'($signed(d));
      w = v & 31;
      if (v >= -16 && v <= 15) begin
         ovf = 1'b0;
         o   = w[4:0];
      end else begin
         ovf = 1'b1;
         if (sat) o = (v < 0) ? 5'd16 : 5'd15;
         else     o = w[4:0];
      end
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      in_data   = 8'h00;
      sat_en    = 1'b0;
      out_ready = 1'b1;
      clear_ovf = 1'b0;
      reset_n   = 1'b0;
      @(posedge clock);
      #3;
      reset_n = 1'b1;
      tick();
      m_valid  = 1'b0;
      m_data   = 5'd0;
      m_ovf    = 1'b0;
      m_sticky = 1'b0;
      m_cnt    = 0;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      sat_en    = 1'b0;
      out_ready = 1'b1;
      clear_ovf = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({out_valid, out_data, out_ovf, ovf_sticky, ovf_count} !== 16'h0) begin
         failures++;
         $display("FAIL reset_state: got valid=%b data=%h ovf=%b sticky=%b count=%0d want all 0",
                  out_valid, out_data, out_ovf, ovf_sticky, ovf_count);
      end
      #3;
      reset_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      tick();
   endtask

   task automatic test_sweep();
      logic [4:0] eo;
      logic       ev;
      int         n_ovf;
      do_reset();
      n_ovf = 0;
      for (int i = 0; i < 256; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i);
         sat_en   = 1'b0;
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL sweep_ready[%0d]: got %b want 1", i, in_ready);
         end
         ref_narrow(8'(i), 1'b0, eo, ev);
         if (ev) n_ovf++;
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== eo || out_ovf !== ev) begin
            failures++;
            $display("FAIL sweep_out[%0d]: got v=%b d=%h o=%b want v=1 d=%h o=%b",
                     i, out_valid, out_data, out_ovf, eo, ev);
         end
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (ovf_count !== 8'(n_ovf) || n_ovf != 224 || ovf_sticky !== 1'b1) begin
         failures++;
         $display("FAIL sweep_count: got count=%0d sticky=%b want 224/1 (model %0d)",
                  ovf_count, ovf_sticky, n_ovf);
      end
   endtask

   task automatic test_saturate();
      logic [7:0] vin  [6] = '{8'h7F, 8'h80, 8'h10, 8'hEF, 8'h0F, 8'hF0};
      logic [4:0] vout [6] = '{5'b01111, 5'b10000, 5'b01111, 5'b10000, 5'b01111, 5'b10000};
      logic       vovf [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = vin[i];
         sat_en   = 1'b1;
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== vout[i] || out_ovf !== vovf[i]) begin
            failures++;
            $display("FAIL saturate[%h]: got v=%b d=%b o=%b want v=1 d=%b o=%b",
                     vin[i], out_valid, out_data, out_ovf, vout[i], vovf[i]);
         end
      end
      in_valid = 1'b0;
      sat_en   = 1'b0;
      tick();
   endtask

   task automatic test_roundtrip();
      logic [7:0] ext;
      do_reset();
      for (int v = -16; v <= 15; v++) begin
         in_valid = 1'b1;
         in_data  = 8'(v);
         sat_en   = 1'($urandom_range(0, 1));
         tick();
         ext = {{3{out_data[4]}}, out_data};
         checks++;
         if (ext !== 8'(v) || out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL roundtrip[%0d]: got ext=%h ovf=%b want %h/0", v, ext, out_ovf, 8'(v));
         end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] w0, w1;
      logic [4:0] e0, e1;
      logic       o0, o1;
      do_reset();
      w0 = 8'($urandom);
      w1 = 8'($urandom);
      ref_narrow(w0, 1'b0, e0, o0);
      ref_narrow(w1, 1'b0, e1, o1);
      in_valid  = 1'b1;
      in_data   = w0;
      out_ready = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_first_ready: got %b want 1", in_ready);
      end
      tick();
      in_data = w1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== e0 || out_ovf !== o0) begin
            failures++;
            $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%h o=%b want 0/1/%h/%b",
                     c, in_ready, out_valid, out_data, out_ovf, e0, o0);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_data !== e0) begin
         failures++;
         $display("FAIL bp_release: got rdy=%b d=%h want 1/%h", in_ready, out_data, e0);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== e1 || out_ovf !== o1) begin
         failures++;
         $display("FAIL bp_second: got v=%b d=%h o=%b want 1/%h/%b", out_valid, out_data, out_ovf, e1, o1);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_no_dup: got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_counter();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom_range(16, 127));
         if (i % 2 == 1) in_data = 8'($urandom_range(128, 239));
         tick();
         if (i == 253 || i == 254 || i == 299) begin
            checks++;
            if (ovf_count !== 8'((i + 1 > 255) ? 255 : i + 1) || ovf_sticky !== 1'b1) begin
               failures++;
               $display("FAIL count_sat[%0d]: got %0d sticky=%b want %0d/1",
                        i, ovf_count, ovf_sticky, (i + 1 > 255) ? 255 : i + 1);
            end
         end
      end
      in_valid  = 1'b0;
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      checks++;
      if (ovf_sticky !== 1'b0 || ovf_count !== 8'd0) begin
         failures++;
         $display("FAIL clear_alone: got sticky=%b count=%0d want 0/0", ovf_sticky, ovf_count);
      end
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h40;
         tick();
      end
      checks++;
      if (ovf_count !== 8'd3) begin
         failures++;
         $display("FAIL count_three: got %0d want 3", ovf_count);
      end
      in_data   = 8'hA0;
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      in_valid  = 1'b0;
      checks++;
      if (ovf_sticky !== 1'b1 || ovf_count !== 8'd1 || out_ovf !== 1'b1 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL clear_with_ovf: got sticky=%b count=%0d ovf=%b v=%b want 1/1/1/1",
                  ovf_sticky, ovf_count, out_ovf, out_valid);
      end
      tick();
   endtask

   task automatic test_async_reset();
      do_reset();
      in_valid  = 1'b1;
      in_data   = 8'h55;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || ovf_sticky !== 1'b1 || ovf_count !== 8'd1) begin
         failures++;
         $display("FAIL areset_pre: got v=%b sticky=%b count=%0d want 1/1/1", out_valid, ovf_sticky, ovf_count);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_data, out_ovf, ovf_sticky, ovf_count} !== 16'h0) begin
         failures++;
         $display("FAIL areset_immediate: got v=%b d=%h o=%b sticky=%b count=%0d want all 0",
                  out_valid, out_data, out_ovf, ovf_sticky, ovf_count);
      end
      #2;
      reset_n   = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b1;
      in_data  = 8'hFE;
      sat_en   = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL areset_idle: got v=%b rdy=%b want 0/1", out_valid, in_ready);
      end
      tick();
      in_valid = 1'b0;
      sat_en   = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 5'h1E || out_ovf !== 1'b0) begin
         failures++;
         $display("FAIL areset_first_word: got v=%b d=%h o=%b want 1/1e/0", out_valid, out_data, out_ovf);
      end
      tick();
   endtask

   task automatic test_random_stream();
      logic       exp_rdy;
      logic       acc;
      logic [4:0] nd;
      logic       no;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = 8'($urandom);
         sat_en    = 1'($urandom_range(0, 1));
         clear_ovf = ($urandom_range(0, 15) == 0);
         #1;
         exp_rdy = !m_valid || out_ready;
         checks++;
         if (in_ready !== exp_rdy) begin
            failures++;
            $display("FAIL rand_ready[%0d]: got %b want %b", c, in_ready, exp_rdy);
         end
         acc = in_valid && exp_rdy;
         ref_narrow(in_data, sat_en, nd, no);
         if (acc) begin
            m_valid = 1'b1;
            m_data  = nd;
            m_ovf   = no;
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
         if (acc && no) begin
            m_sticky = 1'b1;
            m_cnt    = clear_ovf ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
         end else if (clear_ovf) begin
            m_sticky = 1'b0;
            m_cnt    = 0;
         end
         tick();
         checks++;
         if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_ovf !== m_ovf)) ||
             ovf_sticky !== m_sticky || ovf_count !== 8'(m_cnt)) begin
            failures++;
            $display("FAIL rand_out[%0d]: got v=%b d=%h o=%b s=%b n=%0d want v=%b d=%h o=%b s=%b n=%0d",
                     c, out_valid, out_data, out_ovf, ovf_sticky, ovf_count,
                     m_valid, m_data, m_ovf, m_sticky, m_cnt);
         end
      end
      in_valid  = 1'b0;
      clear_ovf = 1'b0;
      out_ready = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_saturate();
      test_roundtrip();
      test_back_to_back();
      test_counter();
      test_async_reset();
      test_random_stream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
